sm4_block_packer: RTL and testbench
===================================

Name: sm4_block_packer

Overview:
- Upstream feeder for the pipelined SM4 encrypt/decrypt core.
- Accepts a 32-bit word stream with last/keep markers and packs it into 128-bit blocks.
- Applies PKCS#7 padding at message end and presents blocks on a valid/ready interface matching the core's i_data / i_valid_top / o_ready inputs.
- Sits between the host/DMA word interface and the SM4 core.

Parameters:
- CNT_W, 32, width of the packed-block counter o_blk_cnt.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_s_data  in  32  input word; first-arriving byte in [31:24].
- i_s_valid  in  1  input word valid.
- i_s_last  in  1  word is the final word of the message.
- i_s_keep  in  4  byte-valid mask, MSB-first; meaningful only when i_s_last=1.
- o_s_ready  out  1  packer can accept a word.
- o_data  out  128  packed block; drives the core's i_data.
- o_valid  out  1  block valid; drives the core's i_valid_top.
- i_ready  in  1  core ready; driven by the core's o_ready.
- o_blk_cnt  out  CNT_W  blocks transferred since reset, wraps modulo 2^CNT_W.
- o_err  out  1  sticky illegal-keep flag.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: o_data=0, o_valid=0, o_s_ready=0, o_blk_cnt=0, o_err=0. o_s_ready rises the first cycle after reset release.
- Transfer rules:
  - Word accepted when i_s_valid & o_s_ready.
  - Block transferred when o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_data is held stable.
- Storage: one 128-bit fill register plus the output register o_data. A word count wc (0..3) tracks the fill register.
- Packing order:
  - Word 0 goes to [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0].
  - A full block moves to o_data in the cycle after its 4th word is accepted (latency 1), provided o_data is empty or being transferred in that same cycle.
- Back-pressure: o_s_ready=0 when the fill register is complete (or an end-of-message is pending) and the output register is occupied without a transfer this cycle, or when the FSM is in PAD.
- FSM states:
  - FILL: accept words. On the 4th word, or on a word with i_s_last=1, go to FLUSH.
  - FLUSH: move the fill block to o_data when the output register is free.
    - Non-last block: return to FILL, wc=0.
    - Last word with 16-byte-aligned total length (keep=1111 and wc was 3): go to PAD, which emits an extra block of 16 bytes of 0x10.
    - Otherwise: pad the partial block and return to FILL.
  - PAD: load the extra padding block into o_data when free, then go to FILL.
- Padding rule: with n valid message bytes in the final block (n=1..15), the remaining 16-n bytes each take the value 16-n.
- Legal keep values: 1000, 1100, 1110, 1111 (1..4 bytes). Any other keep on a last word:
  - The word is treated as 1111.
  - o_err is set and stays set until reset.
- Simultaneous load and transfer: if o_data is transferred in the same cycle a new block is ready, the new block is loaded that cycle with no bubble. Sustained throughput is one block per 4 input cycles.
- o_blk_cnt increments on each block transfer, including the padding block.
- Reset mid-message: the partial block is discarded, and wc and the FSM return to FILL.
- Idle ready: i_ready low before key expansion completes simply stalls the packer. No data is lost.

Optional Feature:
- Macro SM4_PKCS7_PAD_EN.
- Defined: PKCS#7 padding as above, including the extra 0x10 block for aligned messages.
- Undefined: the partial final block is zero-filled, no extra block is emitted, and the PAD state is removed. An aligned last word ends the message after the normal block.

Test Plan:
- 8 words 00112233, 44556677, 8899AABB, CCDDEEFF, then 4 more with last, keep=1111, i_ready=1 -> blocks 00112233_44556677_8899AABB_CCDDEEFF, second block, then 101010..10. o_blk_cnt=3.
- Single word 61626364, last, keep=1110 -> o_data=616263_0D0D0D0D0D0D0D0D0D0D0D0D0D (13 pad bytes of 0x0D). With the macro off: 61626300_00000000_00000000_00000000.
- i_ready held 0 for 20 cycles after the first full block -> o_data stable. o_s_ready drops after the 2nd block fills. No word is lost once i_ready=1.
- Continuous words with i_ready=1 -> one block transfer every 4 cycles, no bubble.
- Last word with keep=0101 -> o_err=1 (sticky), word treated as 4 bytes.
- Assert i_rst_n low after 2 words of a block -> all outputs at reset values. The next message packs from word 0.

Source files
------------

// File: rtl/sm4_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : sm4_block_packer
// Description : Packs a 32-bit word stream (last/keep markers) into 128-bit
//               blocks for the SM4 core, with end-of-message padding.
//               Optional macro SM4_PKCS7_PAD_EN: when defined, PKCS#7 padding
//               (including the extra 0x10 block for aligned messages); when
//               undefined, the final partial block is zero-filled.
// Revision    : 1.0 - initial release
// ============================================================================
module sm4_block_packer #(
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_s_data,
  input  logic               i_s_valid,
  input  logic               i_s_last,
  input  logic [3:0]         i_s_keep,
  output logic               o_s_ready,
  output logic [127:0]       o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [CNT_W-1:0]   o_blk_cnt,
  output logic               o_err
);

`ifdef SM4_PKCS7_PAD_EN
  typedef enum logic [1:0] {S_FILL = 2'd0, S_FLUSH = 2'd1, S_PAD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_FILL = 2'd0, S_FLUSH = 2'd1} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_run;       // low only until the first cycle after reset
  logic [1:0]         r_wc;        // words already in the fill register
  logic [127:0]       r_fill;
  logic               r_last;      // fill block ends a message
  logic [4:0]         r_nbytes;    // valid message bytes in the fill block
  logic [127:0]       r_data;
  logic               r_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_out_free;
  logic               w_xfer;
  logic               w_to_pad;
  logic               w_s_ready;
  logic               w_load;
  logic               w_acc;
  logic [1:0]         w_acc_wc;
  logic               w_word_done;
  logic               w_keep_legal;
  logic [2:0]         w_word_bytes;
  logic [4:0]         w_eff_n;
  logic [7:0]         w_pad_val;
  logic [127:0]       w_flush_blk;
  logic [127:0]       w_load_blk;

  assign w_out_free = ~r_valid | i_ready;
  assign w_xfer     = r_valid & i_ready;

`ifdef SM4_PKCS7_PAD_EN
  logic w_last_aligned;
  assign w_last_aligned = r_last & (r_nbytes == 5'd16);
  assign w_to_pad       = w_last_aligned;
`else
  assign w_to_pad       = 1'b0;
`endif

  // A word arriving during FLUSH starts a fresh block, so it lands in slot 0.
  assign w_acc_wc    = (r_state == S_FILL) ? r_wc : 2'd0;
  assign w_acc       = i_s_valid & w_s_ready;
  assign w_word_done = w_acc & (i_s_last | (w_acc_wc == 2'd3));

  // Decode keep into a byte count; illegal masks count as a full word.
  always_comb begin
    w_keep_legal = 1'b1;
    w_word_bytes = 3'd4;
    if (i_s_last) begin
      case (i_s_keep)
        4'b1000: w_word_bytes = 3'd1;
        4'b1100: w_word_bytes = 3'd2;
        4'b1110: w_word_bytes = 3'd3;
        4'b1111: w_word_bytes = 3'd4;
        default: begin
          w_word_bytes = 3'd4;
          w_keep_legal = 1'b0;
        end
      endcase
    end
  end

  // Build the outgoing block: bytes past the message end get the pad value.
  always_comb begin
    w_eff_n = r_last ? r_nbytes : 5'd16;
`ifdef SM4_PKCS7_PAD_EN
    w_pad_val = {3'b000, 5'd16 - w_eff_n};
`else
    w_pad_val = 8'h00;
`endif
    w_flush_blk = r_fill;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) >= w_eff_n) begin
        w_flush_blk[127-8*i -: 8] = w_pad_val;
      end
    end
`ifdef SM4_PKCS7_PAD_EN
    w_load_blk = (r_state == S_PAD) ? {16{8'h10}} : w_flush_blk;
`else
    w_load_blk = w_flush_blk;
`endif
  end

  // FSM next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_FILL: begin
        w_s_ready = r_run;
        if (w_word_done) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_s_ready = r_run & w_out_free & ~w_to_pad;
        if (w_out_free) begin
          w_load = 1'b1;
`ifdef SM4_PKCS7_PAD_EN
          if (w_to_pad)         w_state_nxt = S_PAD;
          else if (w_word_done) w_state_nxt = S_FLUSH;
          else                  w_state_nxt = S_FILL;
`else
          if (w_word_done) w_state_nxt = S_FLUSH;
          else             w_state_nxt = S_FILL;
`endif
        end
      end
`ifdef SM4_PKCS7_PAD_EN
      S_PAD: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
`endif
      default: w_state_nxt = S_FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FILL;
    else          r_state <= w_state_nxt;
  end

  // Input side: pack accepted words and remember end-of-message length.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_wc     <= 2'd0;
      r_fill   <= 128'd0;
      r_last   <= 1'b0;
      r_nbytes <= 5'd0;
      r_err    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_acc) begin
        case (w_acc_wc)
          2'd0: r_fill[127:96] <= i_s_data;
          2'd1: r_fill[95:64]  <= i_s_data;
          2'd2: r_fill[63:32]  <= i_s_data;
          default: r_fill[31:0] <= i_s_data;
        endcase
        r_wc <= w_word_done ? 2'd0 : (w_acc_wc + 2'd1);
        if (i_s_last & ~w_keep_legal) r_err <= 1'b1;
      end
      if (w_word_done) begin
        r_last   <= i_s_last;
        r_nbytes <= {1'b0, w_acc_wc, 2'b00} + {2'b00, w_word_bytes};
      end
    end
  end

  // Output register: load when free, otherwise hold until transferred.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= 128'd0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_load_blk;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // Transferred-block counter, wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (w_xfer) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign o_s_ready = w_s_ready;
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_blk_cnt = r_cnt;
  assign o_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sm4_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm4_block_packer
// Description : Self-checking bench for sm4_block_packer with a byte-level
//               message model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm4_block_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_data = 32'd0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [3:0]   s_keep = 4'd0;
  logic         s_ready;
  logic [127:0] o_data;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [31:0]  blk_cnt;
  logic         o_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_cnt = 0;

  // model state
  logic [7:0]   msg[$];
  logic [127:0] exp_q[$];
  logic [127:0] log_q[$];
  int           xfer_cyc[$];
  logic [31:0]  exp_cnt = 0;
  logic         exp_err = 0;
  logic         have_prev = 0;
  logic [127:0] prev_data = 0;

  sm4_block_packer #(.CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_data(s_data), .i_s_valid(s_valid),
    .i_s_last(s_last), .i_s_keep(s_keep), .o_s_ready(s_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_blk_cnt(blk_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] pack16();
    logic [127:0] b = '0;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = msg[i];
    return b;
  endfunction

  // Message-level model: collect bytes, cut 16-byte blocks, pad at the end.
  task automatic model_word(input logic [31:0] d, input logic last, input logic [3:0] keep);
    int nb;
    int n;
    nb = 4;
    if (last) begin
      case (keep)
        4'b1000: nb = 1;
        4'b1100: nb = 2;
        4'b1110: nb = 3;
        4'b1111: nb = 4;
        default: begin nb = 4; exp_err = 1'b1; end
      endcase
    end
    for (int i = 0; i < nb; i++) msg.push_back(d[31-8*i -: 8]);
    if (!last) begin
      if (msg.size() == 16) begin exp_q.push_back(pack16()); msg.delete(); end
    end else begin
      n = msg.size();
      if (n == 16) begin
        exp_q.push_back(pack16());
`ifdef SM4_PKCS7_PAD_EN
        exp_q.push_back({16{8'h10}});
`endif
      end else begin
        for (int i = n; i < 16; i++) begin
`ifdef SM4_PKCS7_PAD_EN
          msg.push_back(8'(16 - n));
`else
          msg.push_back(8'h00);
`endif
        end
        exp_q.push_back(pack16());
      end
      msg.delete();
    end
  endtask

  // Compare process: counter, sticky error, stall stability, transferred blocks.
  always @(negedge clk) begin
    if (!rst_n) begin
      msg.delete();
      exp_q.delete();
      exp_cnt = 0;
      exp_err = 0;
      have_prev = 0;
    end else begin
      check("blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
      check("err", 128'(o_err), 128'(exp_err));
      if (have_prev) begin
        check("stall_valid", 128'(o_valid), 128'd1);
        check("stall_data", o_data, prev_data);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("unexpected_block", o_data, 128'hx);
        else check("block", o_data, exp_q.pop_front());
        log_q.push_back(o_data);
        xfer_cyc.push_back(cyc);
        exp_cnt = exp_cnt + 1;
      end
      have_prev = o_valid && !i_ready;
      prev_data = o_data;
      if (s_valid && s_ready) model_word(s_data, s_last, s_keep);
    end
  end

  task automatic send(input logic [31:0] d, input logic last, input logic [3:0] keep);
    int waited;
    waited = 0;
    s_data = d; s_last = last; s_keep = keep; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 300) begin
        check("send_timeout", 128'(waited), 128'd0);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    stall_cnt += waited;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 300) begin
      @(negedge clk); n++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // reset values
    #3;
    check("rst_data", o_data, 128'd0);
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_sready", 128'(s_ready), 128'd0);
    check("rst_cnt", 128'(blk_cnt), 128'd0);
    check("rst_err", 128'(o_err), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // aligned two-block message
    log_q.delete();
    send(32'h00112233, 0, 4'hF); send(32'h44556677, 0, 4'hF);
    send(32'h8899AABB, 0, 4'hF); send(32'hCCDDEEFF, 0, 4'hF);
    send(32'h01234567, 0, 4'hF); send(32'h89ABCDEF, 0, 4'hF);
    send(32'hFEDCBA98, 0, 4'hF); send(32'h76543210, 1, 4'hF);
    wait_drain();
    check("t1_blk0", log_q.size() > 0 ? log_q[0] : 128'hx, 128'h00112233_44556677_8899AABB_CCDDEEFF);
`ifdef SM4_PKCS7_PAD_EN
    check("t1_pad", log_q.size() > 2 ? log_q[2] : 128'hx, {16{8'h10}});
    check("t1_cnt", 128'(blk_cnt), 128'd3);
`else
    check("t1_cnt", 128'(blk_cnt), 128'd2);
`endif

    // single short word
    log_q.delete();
    send(32'h61626364, 1, 4'b1110);
    wait_drain();
`ifdef SM4_PKCS7_PAD_EN
    check("t2_pad13", log_q.size() > 0 ? log_q[0] : 128'hx, 128'h6162630D0D0D0D0D0D0D0D0D0D0D0D0D);
`else
    check("t2_zero", log_q.size() > 0 ? log_q[0] : 128'hx, 128'h61626300_00000000_00000000_00000000);
`endif

    // back-pressure: core not ready for 20 cycles
    i_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) send(32'hA0000000 + 32'(k), (k == 11), 4'hF);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        check("t3_sready_low", 128'(s_ready), 128'd0);
        check("t3_valid_held", 128'(o_valid), 128'd1);
        i_ready = 1'b1;
      end
    join
    wait_drain();

    // sustained throughput
    xfer_cyc.delete();
    stall_cnt = 0;
    for (int k = 0; k < 16; k++) send(32'h5A000000 + 32'(k * 3), (k == 15), 4'hF);
    wait_drain();
    check("t4_no_stall", 128'(stall_cnt), 128'd0);
    for (int k = 1; k < 4; k++)
      check("t4_gap", xfer_cyc.size() > k ? 128'(xfer_cyc[k] - xfer_cyc[k-1]) : 128'hx, 128'd4);

    // illegal keep
    log_q.delete();
    send(32'hAABBCCDD, 1, 4'b0101);
    wait_drain();
    check("t5_err", 128'(o_err), 128'd1);
`ifdef SM4_PKCS7_PAD_EN
    check("t5_blk", log_q.size() > 0 ? log_q[0] : 128'hx, 128'hAABBCCDD_0C0C0C0C_0C0C0C0C_0C0C0C0C);
`else
    check("t5_blk", log_q.size() > 0 ? log_q[0] : 128'hx, 128'hAABBCCDD_00000000_00000000_00000000);
`endif
    send(32'h10203040, 1, 4'b1000);
    wait_drain();
    check("t5_err_sticky", 128'(o_err), 128'd1);

    // reset mid-message
    send(32'hDEADBEEF, 0, 4'hF); send(32'hCAFEF00D, 0, 4'hF);
    rst_n = 1'b0;
    #2;
    check("t6_data", o_data, 128'd0);
    check("t6_valid", 128'(o_valid), 128'd0);
    check("t6_sready", 128'(s_ready), 128'd0);
    check("t6_cnt", 128'(blk_cnt), 128'd0);
    check("t6_err", 128'(o_err), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
    send(32'h11111111, 0, 4'hF); send(32'h22222222, 0, 4'hF);
    send(32'h33333333, 0, 4'hF); send(32'h4444FFFF, 1, 4'b1100);
    wait_drain();
`ifdef SM4_PKCS7_PAD_EN
    check("t6_blk", log_q.size() > 0 ? log_q[0] : 128'hx, 128'h11111111_22222222_33333333_44440202);
`else
    check("t6_blk", log_q.size() > 0 ? log_q[0] : 128'hx, 128'h11111111_22222222_33333333_44440000);
`endif
    check("t6_cnt_after", 128'(blk_cnt), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
